mult_div_unit: RTL and testbench

//   Multi-cycle multiply/divide unit of the EX stage, beside the ALU, fed the same forwarded A/B operands.

---
 rtl/mult_div_unit.sv | 118 +++++++++++
 tb/tb_mult_div_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Result is computed at accept time and released after a fixed latency.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXN =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXN + 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [63:0]     tmp_q;
  logic            keep_q;

  logic signed [63:0] sa_w;
  logic signed [63:0] sb_w;
  logic [63:0]     prod_s;
  logic [63:0]     prod_u;
  logic [31:0]     abs_a;
  logic [31:0]     abs_b;
  logic [31:0]     uq;
  logic [31:0]     ur;
  logic [31:0]     sq;
  logic [31:0]     sr;
  logic [31:0]     dq;
  logic [31:0]     dr;
  logic [31:0]     divb;
  logic            bzero;
  logic [63:0]     res_d;

  always_comb begin
    sa_w   = {{32{A[31]}}, A};
    sb_w   = {{32{B[31]}}, B};
    prod_s = sa_w * sb_w;
    prod_u = {32'b0, A} * {32'b0, B};
    bzero  = (B == 32'b0);
    // Keep the dividers defined when B is zero; that result is dropped.
    divb   = bzero ? 32'd1 : B;
    abs_a  = A[31] ? (~A + 32'd1) : A;
    abs_b  = divb[31] ? (~divb + 32'd1) : divb;
    uq     = abs_a / abs_b;
    ur     = abs_a % abs_b;
    sq     = (A[31] ^ divb[31]) ? (~uq + 32'd1) : uq;
    sr     = A[31] ? (~ur + 32'd1) : ur;
    dq     = A / divb;
    dr     = A % divb;
    res_d  = 64'b0;
    case (md_op)
      3'd0:    res_d = prod_s;
      3'd1:    res_d = prod_u;
      3'd2:    res_d = {sr, sq};
      3'd3:    res_d = {dr, dq};
      default: res_d = 64'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      hi      <= 32'b0;
      lo      <= 32'b0;
      cnt_q   <= '0;
      tmp_q   <= 64'b0;
      keep_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            case (md_op)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                tmp_q   <= res_d;
                keep_q  <= md_op[1] & bzero;
                cnt_q   <= md_op[1] ? CW'(DIV_CYCLES)
                                    : CW'(MULT_CYCLES);
                state_q <= RUN;
                busy    <= 1'b1;
              end
              3'd4:    hi <= A;
              3'd5:    lo <= A;
              default: ;
            endcase
          end
        end
        RUN: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            if (!keep_q) begin
              hi <= tmp_q[63:32];
              lo <= tmp_q[31:0];
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed cases plus random ops
// checked against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;
  logic [31:0] hi_m = 32'b0;
  logic [31:0] lo_m = 32'b0;

  always #5 clk = ~clk;

  mult_div_unit #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .md_op(md_op),
    .A    (A),
    .B    (B),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [2:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    case (op)
      3'd0: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'(sa * sb);
        {hi_m, lo_m} = p;
      end
      3'd1: begin
        p = {32'b0, a} * {32'b0, b};
        {hi_m, lo_m} = p;
      end
      3'd2: if (b != 0) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        lo_m = q[31:0];
        hi_m = r[31:0];
      end
      3'd3: if (b != 0) begin
        lo_m = a / b;
        hi_m = a % b;
      end
      3'd4: hi_m = a;
      3'd5: lo_m = a;
      default: ;
    endcase
  endtask

  task automatic do_op(input logic [2:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input bit inject);
    int n;
    logic [31:0] hi_old, lo_old;
    hi_old = hi_m;
    lo_old = lo_m;
    @(negedge clk);
    start = 1'b1;
    md_op = op;
    A = a;
    B = b;
    @(negedge clk);
    start = 1'b0;
    model(op, a, b);
    n = (op < 3'd2) ? 5 : (op < 3'd4) ? 10 : 0;
    for (int k = 0; k < n; k++) begin
      check("busy_run", {31'b0, busy}, 32'd1);
      if (k == n - 1) begin
        check("hi_hold", hi, hi_old);
        check("lo_hold", lo, lo_old);
      end
      if (inject && k == 1 && n > 2) begin
        start = 1'b1;
        md_op = 3'($urandom_range(0, 5));
        A = $urandom;
        B = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_done", {31'b0, busy}, 32'd0);
    check("hi", hi, hi_m);
    check("lo", lo, lo_m);
  endtask

  task automatic mid_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    hi_m = 32'b0;
    lo_m = 32'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [31:0] spec [6] = '{32'h0, 32'h1, 32'hFFFFFFFF,
                            32'h80000000, 32'h7FFFFFFF, 32'h2};

  initial begin
    logic [2:0]  op;
    logic [31:0] ra, rb;
    reset = 1'b1;
    start = 1'b0;
    md_op = 3'd0;
    A = 32'b0;
    B = 32'b0;
    #12;
    check("init_busy", {31'b0, busy}, 32'd0);
    check("init_hi", hi, 32'd0);
    check("init_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    do_op(3'd4, 32'hDEADBEEF, 32'h0, 1'b0);
    do_op(3'd5, 32'hCAFEF00D, 32'h0, 1'b0);
    @(negedge clk);
    mid_reset();

    do_op(3'd1, 32'hFFFFFFFF, 32'd2, 1'b0);
    check("multu_hi", hi, 32'h00000001);
    check("multu_lo", lo, 32'hFFFFFFFE);
    do_op(3'd0, 32'hFFFFFFFD, 32'd7, 1'b0);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFEB);
    do_op(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);
    do_op(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
    check("divu_lo", lo, 32'h7FFFFFFC);
    check("divu_hi", hi, 32'h00000001);
    do_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    check("ovf_lo", lo, 32'h80000000);
    check("ovf_hi", hi, 32'h00000000);

    do_op(3'd4, 32'h00001234, 32'h0, 1'b0);
    check("mthi", hi, 32'h00001234);
    do_op(3'd2, 32'h00000055, 32'h0, 1'b1);
    check("dz_hi", hi, 32'h00001234);
    do_op(3'd6, 32'h11111111, 32'h2, 1'b0);

    @(negedge clk);
    start = 1'b1;
    md_op = 3'd0;
    A = 32'd9;
    B = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    mid_reset();
    do_op(3'd0, 32'd9, 32'hFFFFFFFF, 1'b0);
    check("post_rst_lo", lo, 32'hFFFFFFF7);

    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 3) == 0) ? spec[$urandom_range(0, 5)]
                                       : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? spec[$urandom_range(0, 5)]
                                       : $urandom;
      do_op(op, ra, rb, bit'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
